// File: rtl/alu_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_pipe : two-stage valid/ready pipelined ALU with registered N/Z/C/V flags
//            and a completed-transfer counter. Optional: ALU_PIPE_SAT_EN.
// Revision : 1.0
// ----------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             v,
  output logic             n,
  output logic             z,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_PASSB = 3'b100;
  localparam logic [2:0] OP_XOR   = 3'b101;
  localparam logic [2:0] OP_ANDN  = 3'b110;
  localparam logic [2:0] OP_NOTA  = 3'b111;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [2:0]       s1_op_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             c_q, v_q, n_q, z_q;
  logic [CNT_W-1:0] cnt_q;

  logic             in_xfer;
  logic             out_xfer;
  logic             s2_load;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             arith;
  logic             ovf;
  logic [WIDTH-1:0] result_d;
  logic             c_d, v_d, n_d, z_d;

  // S2 may load whenever its current contents leave this cycle or it is empty.
  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || !out_valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    b_eff    = (s1_op_q == OP_SUB) ? ~s1_b_q : s1_b_q;
    sum      = {1'b0, s1_a_q} + {1'b0, b_eff} + (WIDTH+1)'(s1_op_q == OP_SUB);
    arith    = (s1_op_q == OP_ADD) || (s1_op_q == OP_SUB);
    // SUB runs through the adder with ~b, so one overflow rule covers both.
    ovf      = arith && (s1_a_q[WIDTH-1] == b_eff[WIDTH-1])
                     && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
    result_d = '0;
    case (s1_op_q)
      OP_ADD:   result_d = sum[WIDTH-1:0];
      OP_SUB:   result_d = sum[WIDTH-1:0];
      OP_AND:   result_d = s1_a_q & s1_b_q;
      OP_OR:    result_d = s1_a_q | s1_b_q;
      OP_PASSB: result_d = s1_b_q;
      OP_XOR:   result_d = s1_a_q ^ s1_b_q;
      OP_ANDN:  result_d = s1_a_q & ~s1_b_q;
      OP_NOTA:  result_d = ~s1_a_q;
      default:  result_d = '0;
    endcase
`ifdef ALU_PIPE_SAT_EN
    // On overflow the true sign is the sign of a.
    if (ovf) begin
      result_d = s1_a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
`endif
    c_d = arith && sum[WIDTH];
    v_d = ovf;
    n_d = result_d[WIDTH-1];
    z_d = (result_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
    end else begin
      if (in_xfer) begin
        s1_valid_q <= 1'b1;
        s1_a_q     <= a;
        s1_b_q     <= b;
        s1_op_q    <= alu_control;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (s2_load) begin
        out_valid_q <= 1'b1;
        result_q    <= result_d;
        c_q         <= c_d;
        v_q         <= v_d;
        n_q         <= n_d;
        z_q         <= z_d;
      end else if (out_xfer) begin
        out_valid_q <= 1'b0;
      end
      if (out_xfer) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign c         = c_q;
  assign v         = v_q;
  assign n         = n_q;
  assign z         = z_q;
  assign op_count  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_pipe : directed self-checking bench for alu_pipe (WIDTH=8).
// Revision    : 1.0
// ----------------------------------------------------------------------------
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] alu_control = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;
  logic       c, v, n, z;
  logic [15:0] op_count;

  logic       k_in_valid = 1'b0;
  logic       k_in_ready;
  logic [7:0] k_a = 8'h01;
  logic [7:0] k_b = 8'h01;
  logic       k_out_valid;
  logic       k_out_ready = 1'b0;
  logic [7:0] k_result;
  logic       k_c, k_v, k_n, k_z;
  logic [3:0] k_op_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_control(alu_control),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .c(c), .v(v), .n(n), .z(z), .op_count(op_count)
  );

  alu_pipe #(.WIDTH(8), .CNT_W(4)) u_cnt (
    .clk(clk), .rst(rst), .in_valid(k_in_valid), .in_ready(k_in_ready),
    .a(k_a), .b(k_b), .alu_control(3'b000),
    .out_valid(k_out_valid), .out_ready(k_out_ready), .result(k_result),
    .c(k_c), .v(k_v), .n(k_n), .z(k_z), .op_count(k_op_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_vec++;
    if ({out_valid, result, c, v, n, z, op_count} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got ov=%b res=%h cvnz=%b%b%b%b cnt=%0d, want all zero",
               out_valid, result, c, v, n, z, op_count);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_add_overflow();
    logic [7:0] exp_res;
    logic [3:0] exp_f;
`ifdef ALU_PIPE_SAT_EN
    exp_res = 8'h7F; exp_f = 4'b0100;
`else
    exp_res = 8'h80; exp_f = 4'b0110;
`endif
    apply_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; a = 8'h7F; b = 8'h01; alu_control = 3'b000;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL add_latency_t1: out_valid got %b want 0", out_valid);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || result !== exp_res || {c, v, n, z} !== exp_f) begin
      n_err++;
      $display("FAIL add_ovf: got ov=%b res=%h cvnz=%b%b%b%b want ov=1 res=%h cvnz=%b",
               out_valid, result, c, v, n, z, exp_res, exp_f);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || op_count !== 16'd1) begin
      n_err++;
      $display("FAIL add_drain: got ov=%b cnt=%0d want ov=0 cnt=1", out_valid, op_count);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; alu_control = 3'b001; a = 8'h05; b = 8'h05;
    tick();
    a = 8'h03; b = 8'h05;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || result !== 8'h00 || {c, v, n, z} !== 4'b1001) begin
      n_err++;
      $display("FAIL sub_equal: got ov=%b res=%h cvnz=%b%b%b%b want ov=1 res=00 cvnz=1001",
               out_valid, result, c, v, n, z);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || result !== 8'hFE || {c, v, n, z} !== 4'b0010) begin
      n_err++;
      $display("FAIL sub_borrow: got ov=%b res=%h cvnz=%b%b%b%b want ov=1 res=fe cvnz=0010",
               out_valid, result, c, v, n, z);
    end
    tick();
    n_vec++;
    if (op_count !== 16'd2 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_count: got cnt=%0d ov=%b want cnt=2 ov=0", op_count, out_valid);
    end
  endtask

  task automatic test_all_opcodes();
    logic [7:0] exp_r [8];
    exp_r = '{8'h1D, 8'h69, 8'h42, 8'hDB, 8'h5A, 8'h99, 8'h81, 8'h3C};
    apply_reset();
    out_ready = 1'b1;
    a = 8'hC3; b = 8'h5A;
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        in_valid = 1'b1; alu_control = 3'(k);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (k >= 1) begin
        n_vec++;
        if (out_valid !== 1'b1 || result !== exp_r[k-1]) begin
          n_err++;
          $display("FAIL opcode_%0d: got ov=%b res=%h want ov=1 res=%h",
                   k-1, out_valid, result, exp_r[k-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] op_a [4];
    logic [7:0] op_b [4];
    logic [2:0] op_c [4];
    logic [7:0] exp_r [4];
    logic [7:0] got [$];
    int idx;
    logic rdy;
    op_a  = '{8'h01, 8'h09, 8'hF0, 8'h10};
    op_b  = '{8'h02, 8'h04, 8'h0F, 8'h01};
    op_c  = '{3'b000, 3'b001, 3'b101, 3'b011};
    exp_r = '{8'h03, 8'h05, 8'hFF, 8'h11};
    apply_reset();
    idx = 0;
    for (int k = 0; k < 7; k++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        a = op_a[idx]; b = op_b[idx]; alu_control = op_c[idx];
      end
      #1;
      rdy = in_ready;
      if (k >= 2) begin
        n_vec++;
        if (rdy !== 1'b0 || out_valid !== 1'b1 || result !== 8'h03) begin
          n_err++;
          $display("FAIL stall_hold_%0d: got rdy=%b ov=%b res=%h want rdy=0 ov=1 res=03",
                   k, rdy, out_valid, result);
        end
      end
      @(posedge clk);
      #1;
      if (in_valid && rdy) idx++;
    end
    n_vec++;
    if (idx != 2) begin
      n_err++;
      $display("FAIL stall_accepted: got %0d want 2", idx);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20 && got.size() < 4; k++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        a = op_a[idx]; b = op_b[idx]; alu_control = op_c[idx];
      end
      #1;
      rdy = in_ready;
      if (out_valid === 1'b1) got.push_back(result);
      @(posedge clk);
      #1;
      if (in_valid && rdy) idx++;
    end
    in_valid = 1'b0;
    n_vec++;
    if (got.size() != 4) begin
      n_err++;
      $display("FAIL bp_count: got %0d results want 4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_vec++;
      if (got[i] !== exp_r[i]) begin
        n_err++;
        $display("FAIL bp_order_%0d: got %h want %h", i, got[i], exp_r[i]);
      end
    end
    n_vec++;
    if (op_count !== 16'd4) begin
      n_err++;
      $display("FAIL bp_op_count: got %0d want 4", op_count);
    end
  endtask

  task automatic test_reset_inflight();
    logic seen;
    apply_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; a = 8'h0F; b = 8'h01; alu_control = 3'b000;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'h44; b = 8'h22; alu_control = 3'b011;
    tick();
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, result, c, v, n, z, op_count} !== '0) begin
      n_err++;
      $display("FAIL rst_inflight: got ov=%b res=%h cvnz=%b%b%b%b cnt=%0d want all zero",
               out_valid, result, c, v, n, z, op_count);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0 || op_count !== 16'd0) begin
      n_err++;
      $display("FAIL rst_stale: got stale=%b cnt=%0d want stale=0 cnt=0", seen, op_count);
    end
  endtask

  task automatic test_counter_wrap();
    int xfers;
    apply_reset();
    xfers = 0;
    k_out_ready = 1'b1;
    for (int k = 0; k < 21; k++) begin
      k_in_valid = (k < 17);
      #1;
      if (k_out_valid === 1'b1) xfers++;
      @(posedge clk);
      #1;
    end
    k_in_valid = 1'b0;
    n_vec++;
    if (xfers != 17 || k_op_count !== 4'd1) begin
      n_err++;
      $display("FAIL cnt_wrap: got xfers=%0d cnt=%0d want xfers=17 cnt=1", xfers, k_op_count);
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_all_opcodes();
    test_backpressure();
    test_reset_inflight();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised successor of the team's 8-bit ALU, generalised to WIDTH bits.
- Two-stage pipelined ALU with valid/ready handshakes on input and output. Backpressure is handled without losing operations.
- Result and N/Z/C/V flags are registered together with the result. The deprecated divide-by-two negedge update scheme is replaced by a single posedge clock domain.
- Sits between the datapath register file and the writeback stage of the 8-bit processor.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and opcode presented.
- in_ready  out  1  block can accept an operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- alu_control  in  3  opcode.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- c, v, n, z  out  1 each  carry, signed overflow, negative, zero; registered with result.
- op_count  out  CNT_W  number of completed output transfers; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync deassert at the flop level):
  - Stage-1 and stage-2 valids = 0; result = 0; c = v = n = z = 0; op_count = 0.
  - in_ready = 1 after reset releases.
  - Reset mid-operation discards all in-flight operations; no partial output.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_valid, result and flags stay stable while out_valid && !out_ready.
- Pipeline:
  - S1 registers a, b and alu_control on input transfer.
  - S2 (the output register) computes from S1 and loads result and flags.
  - S2 loads when S1 is valid and (!out_valid || out_ready).
  - S1 advances when S2 loads, or when S1 is empty.
  - in_ready = !s1_valid || (!out_valid || out_ready); combinational from out_ready.
- Latency and throughput:
  - Input accepted in cycle T gives out_valid at T+2 when unstalled.
  - Throughput is 1 op/cycle with out_ready held high.
  - With out_ready low, two operations are held (S1 + S2) and in_ready drops; nothing is dropped or duplicated.
- Opcodes:
  - 000 ADD: a+b.
  - 001 SUB: a+~b+1.
  - 010 AND: a&b.
  - 011 OR: a|b.
  - 100 PASSB: b.
  - 101 XOR: a^b.
  - 110 ANDN: a&~b.
  - 111 NOTA: ~a.
- Arithmetic is modulo 2^WIDTH.
- Flags:
  - z = (result == 0).
  - n = result[WIDTH-1].
  - c = carry out of bit WIDTH-1 for ADD/SUB. For SUB, c = 1 means no borrow (a ≥ b unsigned). c = 0 for logic ops.
  - v = two's-complement overflow for ADD (operands same sign, result differs) and SUB (operands differ in sign, result sign ≠ a's). v = 0 for logic ops.
- Counter:
  - op_count increments by 1 on each output transfer.
  - Wraps from 2^CNT_W-1 to 0.
- Simultaneous input and output transfer in one cycle is legal and required for full throughput.

Optional Feature:
- Macro: ALU_PIPE_SAT_EN.
- Defined:
  - ADD/SUB with signed overflow saturate result to the signed maximum (0111…1) or minimum (1000…0), in the direction of the true sign.
  - v still reports 1 on overflow.
  - n and z are computed from the saturated result.
  - c is unaffected by saturation.
- Undefined: results wrap modulo 2^WIDTH; no saturation logic is synthesised.

Test Plan (WIDTH=8 unless noted):
- Reset, then ADD a=0x7F b=0x01 with out_ready=1 -> out_valid at T+2, result=0x80, n=1, v=1, c=0, z=0. With ALU_PIPE_SAT_EN: result=0x7F, n=0, v=1.
- SUB a=0x05 b=0x05, then SUB a=0x03 b=0x05 back-to-back -> first: result=0x00, z=1, c=1, v=0. Second: result=0xFE, n=1, c=0. Consecutive cycles; op_count=2.
- Stream all 8 opcodes with a=0xC3 b=0x5A, out_ready=1 -> results 0x1D, 0x69, 0x42, 0xDB, 0x5A, 0x99, 0x81, 0x3C in order, one per cycle.
- Hold out_ready=0 while presenting 4 ops -> exactly 2 accepted, in_ready=0. Output stable for 5 cycles. Raise out_ready -> remaining ops accepted and all 4 results emitted in order, no loss or duplication.
- Assert rst with 2 ops in flight -> out_valid=0, result=0, flags=0, op_count=0 immediately, before the next clk edge. No stale result after release.
- CNT_W=4, 17 transfers -> op_count reads 1.
